// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory bus arbiter and its picker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Requester indices are carried at the width of the largest supported group
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    // Index of the set bit in a one-hot vector; zero for an all-zero vector
    function automatic logic [IDX_W-1:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx |= IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner picker: optional strict priority for requester 0, else round-robin from a pointer.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the winner is consumed.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter bit PRIO0   = 1'b1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_vld
);

    // Lowest asserted index at or above the pointer wins; if none, lowest asserted index overall
    always_comb begin
        o_gnt = '0;
        if (PRIO0 && i_req[0]) begin
            o_gnt[0] = 1'b1;
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (i_req[i]) begin
                    o_gnt    = '0;
                    o_gnt[i] = 1'b1;
                end
            end
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (i_req[i] && (i >= int'(i_rr_ptr))) begin
                    o_gnt    = '0;
                    o_gnt[i] = 1'b1;
                end
            end
        end
    end

    assign o_vld = |o_gnt;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous-read memory bus between NUM_REQ requesters with req/gnt/ack, round-robin and burst lock.
// Latency: write ack 2 cycles, read ack 3 cycles after req is sampled in IDLE; all outputs registered.
// Backpressure: requesters hold req/we/addr/wdata until ack; losers and non-owners during a lock simply wait.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter bit PRIO0   = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_lock,
    input  logic [NUM_REQ-1:0]        i_we,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_ack,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [ADDR_W-1:0]         o_bus_addr,
    output logic [DATA_W-1:0]         o_bus_wdata,
    output logic                      o_bus_we,
    input  logic [DATA_W-1:0]         i_bus_rdata,
    output logic                      o_busy
);

    arb_state_t          r_state,     w_state_nxt;
    logic [NUM_REQ-1:0]  r_gnt,       w_gnt_nxt;
    logic [NUM_REQ-1:0]  r_ack,       w_ack_nxt;
    logic [DATA_W-1:0]   r_rdata,     w_rdata_nxt;
    logic [ADDR_W-1:0]   r_bus_addr,  w_addr_nxt;
    logic [DATA_W-1:0]   r_bus_wdata, w_wdata_nxt;
    logic                r_bus_we,    w_bus_we_nxt;
    logic                r_we,        w_we_nxt;
    logic [IDX_W-1:0]    r_rr_ptr,    w_ptr_nxt;
    logic                r_lock_vld,  w_lock_nxt;
    logic                r_busy,      w_busy_nxt;

    logic                w_lock_hold;
    logic [NUM_REQ-1:0]  w_pick_req;
    logic [NUM_REQ-1:0]  w_pick;
    logic                w_pick_vld;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_we;
    logic [IDX_W-1:0]    w_owner;
    logic [IDX_W-1:0]    w_ptr_inc;

    // A held lock survives while the owner still requests or still asserts lock;
    // once both drop, everyone competes again in the same cycle
    assign w_lock_hold = r_lock_vld & ((|(i_req & r_gnt)) | (|(i_lock & r_gnt)));
    assign w_pick_req  = w_lock_hold ? (i_req & r_gnt) : i_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PRIO0   (PRIO0)
    ) u_rr_pick (
        .i_req    (w_pick_req),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_pick),
        .o_vld    (w_pick_vld)
    );

    assign w_owner   = oh2idx(MAX_REQ'(r_gnt));
    assign w_ptr_inc = (w_owner == IDX_W'(NUM_REQ - 1)) ? '0 : w_owner + 1'b1;

    // Route the winner's address, write data and direction onto the latch inputs
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_sel_addr  = i_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = i_wdata[i*DATA_W +: DATA_W];
                w_sel_we    = i_we[i];
            end
        end
    end

    // Next-state and next-output decode; ack is set on entry to DONE so it is high during DONE
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_ack_nxt    = '0;
        w_rdata_nxt  = r_rdata;
        w_addr_nxt   = r_bus_addr;
        w_wdata_nxt  = r_bus_wdata;
        w_bus_we_nxt = 1'b0;
        w_we_nxt     = r_we;
        w_ptr_nxt    = r_rr_ptr;
        w_lock_nxt   = r_lock_vld;
        case (r_state)
            IDLE: begin
                w_lock_nxt = w_lock_hold;
                if (w_pick_vld) begin
                    w_gnt_nxt    = w_pick;
                    w_addr_nxt   = w_sel_addr;
                    w_wdata_nxt  = w_sel_wdata;
                    w_we_nxt     = w_sel_we;
                    w_bus_we_nxt = w_sel_we;
                    w_state_nxt  = ACCESS;
                end else begin
                    // A stalled burst keeps the bus owned even with nothing in flight
                    w_gnt_nxt = w_lock_hold ? r_gnt : '0;
                end
            end
            ACCESS: begin
                if (r_we) begin
                    w_ack_nxt   = r_gnt;
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RDWAIT;
                end
            end
            RDWAIT: begin
                w_rdata_nxt = i_bus_rdata;
                w_ack_nxt   = r_gnt;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_ptr_nxt = w_ptr_inc;
                if (|(i_lock & r_gnt)) begin
                    w_lock_nxt = 1'b1;
                end else begin
                    w_lock_nxt = 1'b0;
                    w_gnt_nxt  = '0;
                end
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State and registered outputs; reset aborts any transaction without an ack
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_we    <= 1'b0;
            r_we        <= 1'b0;
            r_rr_ptr    <= '0;
            r_lock_vld  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_ack       <= w_ack_nxt;
            r_rdata     <= w_rdata_nxt;
            r_bus_addr  <= w_addr_nxt;
            r_bus_wdata <= w_wdata_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_we        <= w_we_nxt;
            r_rr_ptr    <= w_ptr_nxt;
            r_lock_vld  <= w_lock_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_ack       = r_ack;
    assign o_rdata     = r_rdata;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_wdata = r_bus_wdata;
    assign o_bus_we    = r_bus_we;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: one PRIO0=1 instance and one PRIO0=0 instance on shared stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, lock, we;
    logic [23:0] addr, wdata;

    logic [2:0]  gnt1, ack1, gnt0, ack0;
    logic [7:0]  rdata1, baddr1, bwd1, rd1;
    logic [7:0]  rdata0, baddr0, bwd0, rd0;
    logic        bwe1, busy1, bwe0, busy0;

    logic [7:0]  mem [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.NUM_REQ(3), .ADDR_W(8), .DATA_W(8), .PRIO0(1'b1)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_lock(lock), .i_we(we),
        .i_addr(addr), .i_wdata(wdata), .o_gnt(gnt1), .o_ack(ack1), .o_rdata(rdata1),
        .o_bus_addr(baddr1), .o_bus_wdata(bwd1), .o_bus_we(bwe1), .i_bus_rdata(rd1),
        .o_busy(busy1)
    );

    mem_bus_arbiter #(.NUM_REQ(3), .ADDR_W(8), .DATA_W(8), .PRIO0(1'b0)) dut_rr (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_lock(lock), .i_we(we),
        .i_addr(addr), .i_wdata(wdata), .o_gnt(gnt0), .o_ack(ack0), .o_rdata(rdata0),
        .o_bus_addr(baddr0), .o_bus_wdata(bwd0), .o_bus_we(bwe0), .i_bus_rdata(rd0),
        .o_busy(busy0)
    );

    // Memory behind the bus: synchronous read, 1-cycle latency; only the main instance writes
    always @(posedge clk) begin
        if (bwe1) mem[baddr1] <= bwd1;
        rd1 <= mem[baddr1];
        rd0 <= mem[baddr0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack1(input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (ack1 != 3'b000) seen = 1'b1;
        end
        chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
    endtask

    // Wait for the next grant of the chosen instance, compare it, then wait for release
    task automatic next_gnt(input bit use_rr, input logic [2:0] exp, input string tag);
        logic [2:0] g;
        logic       rel;
        g = 3'b000;
        for (int n = 0; n < 20 && g == 3'b000; n++) begin
            tick();
            g = use_rr ? gnt0 : gnt1;
        end
        chk(tag, 32'(g), 32'(exp));
        rel = 1'b0;
        for (int n = 0; n < 20 && !rel; n++) begin
            tick();
            if ((use_rr ? gnt0 : gnt1) == 3'b000) rel = 1'b1;
        end
        chk({tag, "_released"}, 32'(rel), 32'd1);
    endtask

    initial begin
        mem[8'h10] = 8'h3C;
        rst_n = 1'b0;
        req   = 3'b111;
        lock  = 3'b000;
        we    = 3'b000;
        addr  = {8'h10, 8'h42, 8'h10};
        wdata = {8'h3C, 8'hA5, 8'h00};

        // Reset with all requests asserted
        tick(); tick();
        chk("rst_gnt",   32'(gnt1),   32'h0);
        chk("rst_ack",   32'(ack1),   32'h0);
        chk("rst_busy",  32'(busy1),  32'h0);
        chk("rst_we",    32'(bwe1),   32'h0);
        chk("rst_addr",  32'(baddr1), 32'h0);
        chk("rst_wdata", 32'(bwd1),   32'h0);
        chk("rst_rdata", 32'(rdata1), 32'h0);

        // Release: requester 0 wins by priority, reads 0x10
        rst_n = 1'b1;
        tick();
        chk("rel_gnt",  32'(gnt1),   32'h1);
        chk("rel_busy", 32'(busy1),  32'h1);
        chk("rel_addr", 32'(baddr1), 32'h10);
        wait_ack1("rel");
        chk("rel_ack",   32'(ack1),   32'h1);
        chk("rel_rdata", 32'(rdata1), 32'h3C);
        req = 3'b000;
        tick();
        chk("rel_idle_gnt", 32'(gnt1), 32'h0);

        // Single write from requester 1
        req = 3'b010; we = 3'b010;
        tick();
        chk("wr_gnt",   32'(gnt1),   32'h2);
        chk("wr_we",    32'(bwe1),   32'h1);
        chk("wr_addr",  32'(baddr1), 32'h42);
        chk("wr_wdata", 32'(bwd1),   32'hA5);
        tick();
        chk("wr_ack",    32'(ack1), 32'h2);
        chk("wr_we_off", 32'(bwe1), 32'h0);
        req = 3'b000; we = 3'b000;
        tick();
        chk("wr_gnt_clr", 32'(gnt1),      32'h0);
        chk("wr_busy",    32'(busy1),     32'h0);
        chk("wr_mem",     32'(mem[8'h42]), 32'hA5);

        // Read from requester 2: ack three cycles after sampling
        req = 3'b100;
        tick();
        chk("rd_gnt", 32'(gnt1), 32'h4);
        chk("rd_we1", 32'(bwe1), 32'h0);
        tick();
        chk("rd_noack", 32'(ack1), 32'h0);
        chk("rd_we2",   32'(bwe1), 32'h0);
        tick();
        chk("rd_ack",   32'(ack1),   32'h4);
        chk("rd_rdata", 32'(rdata1), 32'h3C);
        chk("rd_we3",   32'(bwe1),   32'h0);
        req = 3'b000;
        tick();

        // Round-robin fairness on the PRIO0=0 instance with requests 1 and 2 held
        req = 3'b110; we = 3'b110;
        next_gnt(1'b1, 3'b010, "rr0");
        next_gnt(1'b1, 3'b100, "rr1");
        next_gnt(1'b1, 3'b010, "rr2");
        next_gnt(1'b1, 3'b100, "rr3");
        req = 3'b000; we = 3'b000;
        for (int n = 0; n < 4; n++) tick();

        // Strict priority: requester 0 wins every arbitration while held
        req = 3'b111; we = 3'b111;
        next_gnt(1'b0, 3'b001, "prio0");
        next_gnt(1'b0, 3'b001, "prio1");
        next_gnt(1'b0, 3'b001, "prio2");
        req = 3'b000; we = 3'b000;
        for (int n = 0; n < 4; n++) tick();

        // Locked burst of four writes by requester 1 while requester 2 waits
        req = 3'b110; we = 3'b110; lock = 3'b010;
        for (int k = 0; k < 4; k++) begin
            addr[15:8]  = 8'(8'h20 + k);
            wdata[15:8] = 8'(8'h50 + k);
            wait_ack1("burst");
            chk("burst_ack", 32'(ack1), 32'h2);
        end
        req = 3'b100;
        tick();
        chk("hold_gnt1",  32'(gnt1),  32'h2);
        chk("hold_busy",  32'(busy1), 32'h0);
        tick();
        chk("hold_gnt2",  32'(gnt1),  32'h2);
        chk("burst_mem",  32'(mem[8'h23]), 32'h53);
        lock = 3'b000;
        tick();
        chk("unlock_gnt", 32'(gnt1), 32'h4);
        wait_ack1("unlock");
        chk("unlock_ack", 32'(ack1), 32'h4);
        req = 3'b000; we = 3'b000;
        tick();

        // Asynchronous reset during RDWAIT aborts with no ack
        addr[15:8] = 8'h10;
        req = 3'b010;
        tick();
        tick();
        chk("ab_busy", 32'(busy1), 32'h1);
        chk("ab_ack0", 32'(ack1),  32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab_gnt",  32'(gnt1),  32'h0);
        chk("ab_busy0", 32'(busy1), 32'h0);
        req = 3'b000;
        tick();
        chk("ab_ack1", 32'(ack1), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("ab_ack2", 32'(ack1), 32'h0);
        chk("ab_gnt2", 32'(gnt1), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
